sys_tick_fifo: RTL and testbench



---
 rtl/sys_tick_fifo_pkg.sv | 29 ++
 rtl/sys_tick_fifo_if.sv | 22 ++
 rtl/sys_tick_fifo_tick_divider.sv | 38 +++
 rtl/sys_tick_fifo.sv | 97 +++++++++
 tb/tb_sys_tick_fifo.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sys_tick_fifo_pkg.sv
// Shared constants and types for the tick-rate FIFO slice.
// Default sizes and the operation decoder used by the FIFO core.
package sys_tick_fifo_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int DIV_WIDTH_DEF = 9;
  localparam int PTR_W         = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Both qualifiers are already gated by tick, enable and flag state.
  function automatic fifo_op_e decode_op(input logic do_read, input logic do_write);
    fifo_op_e op;
    case ({do_read, do_write})
      2'b01:   op = OP_WRITE;
      2'b10:   op = OP_READ;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sys_tick_fifo_if.sv
// Producer/consumer side of the tick-rate FIFO: requests, data and flags.
interface sys_tick_fifo_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             read;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  modport master (
    output en, read, write, data_in,
    input  data_out, empty, full
  );

  modport slave (
    input  en, read, write, data_in,
    output data_out, empty, full
  );
endinterface

// File: rtl/sys_tick_fifo_tick_divider.sv
// Programmable divider producing a registered one-clk enable pulse every N clocks.
module tick_divider #(
  parameter int DIV_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] clock_divider,
  output logic                 sys_tick
);

  logic [DIV_WIDTH-1:0] count;
  logic                 wrap;

  // Ratios of 0 and 1 both mean every cycle; a counter already past a newly
  // lowered ratio wraps on the next edge thanks to the >= compare.
  always_comb begin
    wrap = 1'b0;
    if (clock_divider <= DIV_WIDTH'(1)) begin
      wrap = 1'b1;
    end else if (count >= clock_divider - 1'b1) begin
      wrap = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      sys_tick <= 1'b0;
    end else if (wrap) begin
      count    <= '0;
      sys_tick <= 1'b1;
    end else begin
      count    <= count + 1'b1;
      sys_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_tick_fifo.sv
// Circular-buffer FIFO whose pushes and pops advance only on the divided tick.
module sys_tick_fifo
  import sys_tick_fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] clock_divider,
  sys_tick_fifo_if.slave       bus,
  output logic                 sys_tick
);

  localparam int              PW         = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_next;
  logic [WIDTH-1:0] data_q;
  logic             empty_q;
  logic             full_q;
  logic             do_read;
  logic             do_write;
  fifo_op_e         op;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .clk           (clk),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .sys_tick      (sys_tick)
  );

  // A write into a full FIFO is allowed only when a pop frees the slot on
  // the same tick; a read while empty never bypasses the incoming word.
  always_comb begin
    do_read    = 1'b0;
    do_write   = 1'b0;
    count_next = count;
    if (sys_tick && bus.en) begin
      do_read  = bus.read && !empty_q;
      do_write = bus.write && (!full_q || do_read);
    end
    op = decode_op(do_read, do_write);
    case (op)
      OP_WRITE: count_next = count + 1'b1;
      OP_READ:  count_next = count - 1'b1;
      default:  count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == FULL_COUNT);
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out = data_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;

  count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    count <= FULL_COUNT);

  flags_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(empty_q && full_q));

endmodule

// File: tb/tb_sys_tick_fifo.sv
// Directed bench for sys_tick_fifo: fill, drain, wrap, full read/write, enable and divider.
module tb_sys_tick_fifo;
  import sys_tick_fifo_pkg::*;

  localparam int TB_DEPTH = 1 << PTR_W;

  logic        clk;
  logic        reset_n;
  logic [8:0]  clock_divider;
  logic        sys_tick;
  int unsigned cycles;
  int          checks;
  int          failures;

  sys_tick_fifo_if #(.WIDTH(8)) bus ();

  sys_tick_fifo #(
    .WIDTH     (8),
    .DEPTH     (8),
    .DIV_WIDTH (9)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .bus           (bus),
    .sys_tick      (sys_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycles <= cycles + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; waits for a tick, drives the request, ends at the negedge after the operating edge.
  task automatic applyStimulus(input logic en_v, input logic rd_v, input logic wr_v, input logic [7:0] d);
    int waited = 0;
    while (!sys_tick && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (!sys_tick) checkOutput("tick_wait", 32'(sys_tick), 32'd1);
    bus.en      = en_v;
    bus.read    = rd_v;
    bus.write   = wr_v;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned start_cycle;
    logic [7:0] exp_data;

    cycles        = 0;
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b1;
    clock_divider = 9'd2;
    bus.en        = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.data_in   = 8'h00;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_data", 32'(bus.data_out), 32'h0);
    checkOutput("rst_tick", 32'(sys_tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("tick_n2_%0d", i), 32'(sys_tick), (i % 2 == 1) ? 32'd1 : 32'd0);
    end

    // Fill with alternating 55/AA, write held for 16 ticks
    for (int i = 0; i < 2 * TB_DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, (i % 2 == 0) ? 8'h55 : 8'hAA);
      if (i == 0) checkOutput("fill_empty_drop", 32'(bus.empty), 32'd0);
      if (i == 6) checkOutput("fill_not_full_7", 32'(bus.full), 32'd0);
      if (i == 7) checkOutput("fill_full_8", 32'(bus.full), 32'd1);
    end
    checkOutput("fill_full_end", 32'(bus.full), 32'd1);
    checkOutput("fill_data_held", 32'(bus.data_out), 32'h0);

    // Drain
    for (int i = 0; i < TB_DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      exp_data = (i % 2 == 0) ? 8'h55 : 8'hAA;
      checkOutput($sformatf("drain_data_%0d", i), 32'(bus.data_out), 32'(exp_data));
      if (i == 0) checkOutput("drain_full_drop", 32'(bus.full), 32'd0);
      if (i == 6) checkOutput("drain_not_empty_7", 32'(bus.empty), 32'd0);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("underflow_data_%0d", i), 32'(bus.data_out), 32'hAA);
    end

    // Wrap and simultaneous read/write
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i));
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("wrap_pop_%0d", i), 32'(bus.data_out), 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(6 + i));
      checkOutput($sformatf("rw_data_%0d", i), 32'(bus.data_out), 32'(4 + i));
      checkOutput($sformatf("rw_flags_%0d", i), {30'd0, bus.full, bus.empty}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_tail_0", 32'(bus.data_out), 32'h0A);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_tail_1", 32'(bus.data_out), 32'h0B);
    checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

    // Full plus simultaneous read/write
    for (int i = 0; i < TB_DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
    checkOutput("full_before_rw", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    checkOutput("full_rw_head", 32'(bus.data_out), 32'h10);
    checkOutput("full_rw_stays", 32'(bus.full), 32'd1);
    for (int i = 0; i < TB_DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      exp_data = (i == TB_DEPTH - 1) ? 8'h3C : 8'(8'h11 + i);
      checkOutput($sformatf("full_pop_%0d", i), 32'(bus.data_out), 32'(exp_data));
    end
    checkOutput("full_drain_empty", 32'(bus.empty), 32'd1);

    // Enable low freezes everything
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h21);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i % 2 == 0), (i % 2 == 1), 8'hFF);
      checkOutput($sformatf("en0_state_%0d", i),
                  {22'd0, bus.full, bus.empty, bus.data_out}, 32'h03C);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("en1_pop_0", 32'(bus.data_out), 32'h20);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("en1_pop_1", 32'(bus.data_out), 32'h21);
    checkOutput("en1_empty", 32'(bus.empty), 32'd1);

    // Divider ratio 1: tick every clock, one operation per cycle
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    clock_divider = 9'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("tick_n1_%0d", i), 32'(sys_tick), 32'd1);
    end
    start_cycle = cycles;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("n1_pop_%0d", i), 32'(bus.data_out), 32'(8'h30 + i));
    end
    checkOutput("n1_cycles", cycles - start_cycle, 32'd6);

    // Asynchronous reset in the middle of a fill
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h41);
    checkOutput("midfill_not_empty", 32'(bus.empty), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_empty", 32'(bus.empty), 32'd1);
    checkOutput("async_data", 32'(bus.data_out), 32'h0);
    checkOutput("async_tick", 32'(sys_tick), 32'd0);
    bus.write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_empty", 32'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
